// File: rtl/leading_zero_counter_pipelined.sv
// Pipelined leading-zero / leading-one counter.
// Stage 0 counts zeroes within 2-bit pairs; each later stage merges adjacent
// group counts, giving log2(WIDTH) registered levels. Stages form a
// bubble-collapsing valid/ready pipeline with one operand per cycle.
module leading_zero_counter_pipelined #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned TAG_WIDTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_operand,
    input  logic                     in_mode,
    input  logic [TAG_WIDTH-1:0]     in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(WIDTH):0]   out_count,
    output logic                     out_all,
    output logic [TAG_WIDTH-1:0]     out_tag
);

    localparam int unsigned LEVELS = $clog2(WIDTH);

    // Leading ones are counted as leading zeroes of the inverted operand.
    logic [WIDTH-1:0] operand_m;
    assign operand_m = in_operand ^ {WIDTH{in_mode}};

    for (genvar k = 0; k < LEVELS; k++) begin : g_stage
        // Stage k holds WIDTH/2^(k+1) group counts, each k+2 bits wide.
        localparam int unsigned GROUPS = WIDTH >> (k + 1);
        localparam int unsigned CW     = k + 2;

        logic                   valid_q, valid_d;
        logic                   adv;
        logic [GROUPS*CW-1:0]   cnt_q, cnt_d;
        logic [TAG_WIDTH-1:0]   tag_q, tag_d;

        // A stage may load when it is empty or its content moves on this cycle.
        if (k == LEVELS - 1) begin : g_last
            assign adv = ~valid_q | out_ready;
        end else begin : g_mid
            assign adv = ~valid_q | g_stage[k+1].adv;
        end

        if (k == 0) begin : g_pair
            assign valid_d = in_valid & in_ready;
            assign tag_d   = in_tag;

            // Per-pair count: 00 -> 2, 01 -> 1, 1x -> 0.
            always_comb begin
                cnt_d = '0;
                for (int unsigned i = 0; i < WIDTH / 2; i++) begin
                    if (operand_m[2*i+1]) begin
                        cnt_d[2*i +: 2] = 2'd0;
                    end else if (operand_m[2*i]) begin
                        cnt_d[2*i +: 2] = 2'd1;
                    end else begin
                        cnt_d[2*i +: 2] = 2'd2;
                    end
                end
            end
        end else begin : g_merge
            localparam int unsigned PW = k + 1;      // width of incoming counts
            localparam int unsigned N  = 1 << k;     // bits covered by an incoming group

            assign valid_d = g_stage[k-1].valid_q;
            assign tag_d   = g_stage[k-1].tag_q;

            // Upper count below N means a one was found there; otherwise add the lower count.
            // Incoming counts never exceed N, so the MSB alone signals hi == N.
            always_comb begin
                cnt_d = '0;
                for (int unsigned j = 0; j < GROUPS; j++) begin
                    if (g_stage[k-1].cnt_q[(2*j+1)*PW + PW - 1]) begin
                        cnt_d[j*CW +: CW] = CW'(N) + CW'(g_stage[k-1].cnt_q[2*j*PW +: PW]);
                    end else begin
                        cnt_d[j*CW +: CW] = CW'(g_stage[k-1].cnt_q[(2*j+1)*PW +: PW]);
                    end
                end
            end
        end

        // Stage register: cleared on reset, otherwise loads whenever the stage advances.
        always_ff @(posedge clock) begin
            if (reset) begin
                valid_q <= 1'b0;
                cnt_q   <= '0;
                tag_q   <= '0;
            end else if (adv) begin
                valid_q <= valid_d;
                cnt_q   <= cnt_d;
                tag_q   <= tag_d;
            end
        end
    end

    // Outputs are forced quiet while reset is asserted, before the registers clear.
    assign in_ready  = ~reset & g_stage[0].adv;
    assign out_valid = ~reset & g_stage[LEVELS-1].valid_q;
    assign out_count = reset ? '0 : g_stage[LEVELS-1].cnt_q;
    // The count reaches WIDTH only when its MSB is set.
    assign out_all   = ~reset & g_stage[LEVELS-1].cnt_q[LEVELS];
    assign out_tag   = reset ? '0 : g_stage[LEVELS-1].tag_q;

endmodule

// File: doc/leading_zero_counter_pipelined.md
Name: leading_zero_counter_pipelined

Overview:
- Pipelined, parametrised leading-zero / leading-one counter with valid/ready handshakes on both sides.
- The first stage splits the operand into 2-bit pairs and counts the leading zeroes in each pair. Each following stage merges adjacent groups, so the tree has log2(WIDTH) levels.
- A register follows every level. Throughput is one operand per cycle.
- Used by the normaliser and priority logic where a combinational WIDTH-bit count would limit the clock frequency.

Parameters:
- WIDTH, 32, operand width. Must be a power of two and at least 4.
- TAG_WIDTH, 4, width of the sideband tag carried unchanged alongside each operand. Must be at least 1.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand presented.
- in_ready  output  1  block accepts the operand this cycle.
- in_operand  input  WIDTH  value to count.
- in_mode  input  1  0 = count leading zeroes; 1 = count leading ones.
- in_tag  input  TAG_WIDTH  sideband, returned with the result.
- out_valid  output  1  result presented.
- out_ready  input  1  consumer accepts the result.
- out_count  output  log2(WIDTH)+1  number of leading zeroes (or ones), range 0..WIDTH.
- out_all  output  1  high when out_count == WIDTH (operand entirely zeroes, or entirely ones in mode 1).
- out_tag  output  TAG_WIDTH  tag captured with this operand.

Behaviour:
- Definitions: LEVELS = log2(WIDTH). Stage 0 is the pair-count stage; stages 1..LEVELS-1 are merge stages. Each stage has a valid bit and a data register.
- Mode 1 inverts the operand on entry, then counts leading zeroes. Mode is not otherwise stored.
- Stage 0, for each pair {h,l}:
  - 00 gives 2
  - 01 gives 1
  - 10 or 11 gives 0
  - Each pair count is 2 bits wide.
- Merge of an upper group count hi and a lower group count lo, each group n bits wide:
  - result = hi if hi < n
  - result = n + lo otherwise
  - Result width grows by one bit per level. The final width is log2(WIDTH)+1, and there is no overflow at the final level.
- Latency: a result is valid exactly LEVELS cycles after the accepting handshake when the pipeline is not stalled. Example: WIDTH=16 gives 4 cycles.
- Handshake:
  - A transfer occurs on a cycle where valid and ready are both high.
  - in_ready must not depend combinationally on in_valid.
  - out_valid, out_count, out_all and out_tag hold stable while out_valid is high and out_ready is low.
- Bubble-collapsing pipeline:
  - Stage k advances when it is empty or when stage k+1 advances.
  - The last stage advances when out_ready is high or it is empty.
  - in_ready = stage 0 can advance.
  - A full pipeline under permanent backpressure holds exactly LEVELS results, and in_ready is low.
  - Empty stages downstream of a stall still fill.
- Simultaneous accept and emit: allowed in the same cycle. Full throughput holds with out_ready held high.
- Reset:
  - While reset is high: all stage valid bits clear, out_valid=0, out_count=0, out_all=0, out_tag=0, in_ready=0.
  - Inputs are ignored while reset is high.
  - in_ready rises the cycle after reset falls.
  - Reset mid-operation discards every in-flight operand; no result for it is ever emitted.
- Boundaries:
  - Operand 0 gives count WIDTH and out_all=1.
  - An operand with the MSB set (mode 0) gives 0.
  - All ones in mode 1 gives WIDTH and out_all=1.
  - in_valid with in_ready low is not consumed; the producer must hold its inputs.

Test Plan:
- WIDTH=16: after reset, one transfer each of 0x0001, 0x8000, 0x0000 and 0x00F0 (mode 0) -> counts 15, 0, 16 (out_all=1) and 8. Each appears 4 cycles after its accept, in order, with its tag returned.
- Mode 1: operands 0xFFF0, 0xFFFF and 0x7FFF -> counts 12, 16 (out_all=1) and 0.
- Throughput: 20 back-to-back random operands, out_ready held high -> in_ready stays high, 20 results arrive on consecutive cycles, and every value matches the reference count.
- Backpressure: out_ready low for 10 cycles while in_valid is held high -> exactly 4 operands accepted, then in_ready low. out_valid and out_count are held stable. On release, results drain in order with no loss or duplication.
- Reset mid-flight: 3 operands accepted, then reset for 1 cycle -> out_valid is 0 through reset and the following 4 cycles; no stale results; in_ready is 1 the cycle after reset falls.
- Parameter sweep: WIDTH=4 and WIDTH=64 with random operands, random out_ready and random modes -> results match the reference count, and latencies are 2 and 6 cycles respectively when unstalled.
